// File: rtl/sram_ctrl_pkg.sv
// Shared sizing constants and FSM encoding for the masked-write SRAM array controller.
package sram_ctrl_pkg;

  localparam int ADDR_W     = 13;
  localparam int LANES      = 6;
  localparam int LANE_W     = 29;
  localparam int DATA_W     = LANES * LANE_W;
  localparam int RESP_DEPTH = 3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sram_array_ctrl_if.sv
// Request/response channels plus the single-port SRAM macro port of the array controller.
// Handshakes: a transfer happens at a rising edge where valid && ready; valid never waits
// on ready, while ready may depend on the valid of the competing request channel.
interface sram_array_ctrl_if #(
  parameter int ADDR_W = sram_ctrl_pkg::ADDR_W,
  parameter int LANES  = sram_ctrl_pkg::LANES,
  parameter int LANE_W = sram_ctrl_pkg::LANE_W
);

  localparam int DATA_W = LANES * LANE_W;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [LANES-1:0]  wr_mask;

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;

  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [LANES-1:0]  sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  logic              init_done;

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask,
    output wr_ready,
    input  rd_valid, rd_addr,
    output rd_ready,
    output resp_valid, resp_data,
    input  resp_ready,
    output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
    input  sram_rdata,
    output init_done
  );

  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask,
    input  wr_ready,
    output rd_valid, rd_addr,
    input  rd_ready,
    input  resp_valid, resp_data,
    output resp_ready,
    input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
    output sram_rdata,
    input  init_done
  );

endinterface

// File: rtl/sram_resp_fifo.sv
// Small circular response buffer: head is visible combinationally, count feeds the read credit check.
module sram_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = RESP_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    valid   = (count != '0);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_array_ctrl.sv
// Single-port SRAM array controller: post-reset zero sweep, write-priority arbitration with
// read anti-starvation, and a credit-limited response path.
module sram_array_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = sram_ctrl_pkg::ADDR_W,
  parameter int LANES  = sram_ctrl_pkg::LANES,
  parameter int LANE_W = sram_ctrl_pkg::LANE_W
) (
  input  logic                clock,
  input  logic                reset_n,
  sram_array_ctrl_if.slave    bus,
  output state_t              dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t                            state;
  state_t                            state_nxt;
  logic [ADDR_W-1:0]                 init_addr;
  logic [1:0]                        starve_cnt;
  logic                              inflight;
  logic [$clog2(RESP_DEPTH+1)-1:0]   fifo_count;
  logic                              run;
  logic                              rd_may;
  logic                              rd_sel;
  logic                              wr_grant;
  logic                              rd_grant;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_addr == LAST_ADDR) state_nxt = RUN;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_addr  <= '0;
      starve_cnt <= '0;
      inflight   <= 1'b0;
    end else begin
      if (state == INIT) init_addr <= init_addr + 1'b1;
      inflight <= rd_grant;
      if (rd_grant)
        starve_cnt <= '0;
      else if (wr_grant && bus.rd_valid && starve_cnt != 2'd3)
        starve_cnt <= starve_cnt + 2'd1;
    end
  end

  // Reads are credit-limited by buffered plus in-flight responses so the FIFO can never overflow.
  always_comb begin
    run            = (state == RUN);
    rd_may         = ({1'b0, fifo_count} + {2'b00, inflight}) < 3'(RESP_DEPTH);
    rd_sel         = run && bus.rd_valid && rd_may && (!bus.wr_valid || starve_cnt == 2'd3);
    bus.wr_ready   = run && !rd_sel;
    wr_grant       = bus.wr_valid && bus.wr_ready;
    bus.rd_ready   = run && rd_may && !wr_grant;
    rd_grant       = bus.rd_valid && bus.rd_ready;
    bus.init_done  = run;
    dbg_state      = state;

    bus.sram_en    = 1'b0;
    bus.sram_wmode = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wmask = '0;
    bus.sram_wdata = '0;
    if (state == INIT) begin
      // Gated by reset_n so the macro stays quiet while reset is held.
      bus.sram_en    = reset_n;
      bus.sram_wmode = reset_n;
      bus.sram_addr  = init_addr;
      bus.sram_wmask = {LANES{reset_n}};
    end else if (wr_grant) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = 1'b1;
      bus.sram_addr  = bus.wr_addr;
      bus.sram_wmask = bus.wr_mask;
      bus.sram_wdata = bus.wr_data;
    end else if (rd_grant) begin
      bus.sram_en    = 1'b1;
      bus.sram_addr  = bus.rd_addr;
    end
  end

  sram_resp_fifo #(
    .WIDTH (LANES * LANE_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (bus.sram_rdata),
    .pop       (bus.resp_ready),
    .head      (bus.resp_data),
    .valid     (bus.resp_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Bench for sram_array_ctrl: behavioural SRAM macro, table-driven request vectors and
// hand-written sequences for credit limit, arbitration fairness, latency and reset.
module tb_sram_array_ctrl;
  import sram_ctrl_pkg::*;

  typedef struct {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  mask;
    logic [DATA_W-1:0] exp;
  } vec_t;

  logic   clock = 1'b0;
  logic   reset_n = 1'b0;
  state_t dbg_state;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;

  logic [DATA_W-1:0] exp_q[$];
  int                resp_cyc[$];
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always #5 clock = ~clock;

  sram_array_ctrl_if bus ();

  sram_array_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always @(posedge clock) cyc <= cyc + 1;

  // Macro model: masked write, read data one cycle after the enable.
  always @(posedge clock) begin
    if (bus.sram_en) begin
      if (bus.sram_wmode) begin
        for (int l = 0; l < LANES; l++)
          if (bus.sram_wmask[l]) mem[bus.sram_addr][l*LANE_W +: LANE_W] <= bus.sram_wdata[l*LANE_W +: LANE_W];
      end else begin
        bus.sram_rdata <= mem[bus.sram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  always @(negedge clock) begin
    if (reset_n && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) fail_now("resp_unexpected");
      else check("resp_data", bus.resp_data, exp_q.pop_front());
      resp_cyc.push_back(cyc);
    end
  end

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_d, input logic [DATA_W-1:0] new_d,
                                              input logic [LANES-1:0] m);
    logic [DATA_W-1:0] r = old_d;
    for (int l = 0; l < LANES; l++)
      if (m[l]) r[l*LANE_W +: LANE_W] = new_d[l*LANE_W +: LANE_W];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r = '0;
    for (int i = 0; i < 6; i++) r = {r[DATA_W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic idle();
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0;
  endtask

  task automatic realign();
    @(posedge clock); #1;
  endtask

  // Called just after a rising edge; returns just after the edge where the request was taken.
  task automatic do_op(input vec_t v);
    bit got = 0;
    if (v.is_wr) begin
      bus.wr_valid = 1'b1; bus.wr_addr = v.addr; bus.wr_data = v.data; bus.wr_mask = v.mask;
    end else begin
      bus.rd_valid = 1'b1; bus.rd_addr = v.addr;
    end
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clock);
      got = v.is_wr ? bus.wr_ready : bus.rd_ready;
    end
    if (!got) begin
      fail_now(v.is_wr ? "wr_grant_wait" : "rd_grant_wait");
    end else begin
      check("op_en", bus.sram_en, 1'b1);
      check("op_wmode", bus.sram_wmode, v.is_wr);
      check("op_addr", bus.sram_addr, v.addr);
      if (v.is_wr) begin
        check("op_wmask", bus.sram_wmask, v.mask);
        check("op_wdata", bus.sram_wdata, v.data);
      end else begin
        exp_q.push_back(v.exp);
      end
    end
    realign();
    if (v.is_wr) bus.wr_valid = 1'b0;
    else bus.rd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clock);
    if (exp_q.size() != 0) fail_now("drain");
    realign();
  endtask

  // Entered just after the edge at which reset_n is released.
  task automatic init_check();
    int errs = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      @(negedge clock);
      if (!(bus.sram_en && bus.sram_wmode && bus.sram_addr == ADDR_W'(i) && bus.sram_wmask == {LANES{1'b1}} &&
            bus.sram_wdata == '0 && !bus.init_done && !bus.wr_ready && !bus.rd_ready)) errs++;
    end
    check("init_sweep_errs", 32'(errs), 0);
    @(negedge clock);
    check("init_done", bus.init_done, 1'b1);
    check("idle_en", bus.sram_en, 1'b0);
    check("idle_addr", bus.sram_addr, '0);
    check("idle_wmask", bus.sram_wmask, '0);
    realign();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_resp_valid"}, bus.resp_valid, 1'b0);
    check({tag, "_init_done"}, bus.init_done, 1'b0);
    check({tag, "_wr_ready"}, bus.wr_ready, 1'b0);
    check({tag, "_rd_ready"}, bus.rd_ready, 1'b0);
    check({tag, "_sram_en"}, bus.sram_en, 1'b0);
    check({tag, "_state"}, dbg_state, INIT);
  endtask

  initial begin
    vec_t              vecs[10];
    vec_t              v;
    logic [DATA_W-1:0] ones, exp5, d1, d2, d3;
    logic [DATA_W-1:0] wd[4];
    int                grants;
    bit                w, r, got;

    idle();
    bus.resp_ready = 1'b1;
    ones = '1;
    exp5 = '0;
    exp5[0 +: LANE_W] = '1;
    exp5[2*LANE_W +: LANE_W] = '1;
    d1 = rand_data(); d2 = rand_data(); d3 = rand_data();
    vecs[0] = '{1'b1, 13'd5,    ones, 6'b000101, '0};
    vecs[1] = '{1'b0, 13'd5,    '0,   '0,        exp5};
    vecs[2] = '{1'b1, 13'd7,    d1,   6'b111111, '0};
    vecs[3] = '{1'b0, 13'd7,    '0,   '0,        d1};
    vecs[4] = '{1'b1, 13'd7,    d2,   6'b100000, '0};
    vecs[5] = '{1'b0, 13'd7,    '0,   '0,        merge(d1, d2, 6'b100000)};
    vecs[6] = '{1'b0, 13'd100,  '0,   '0,        '0};
    vecs[7] = '{1'b1, 13'd8191, d3,   6'b010010, '0};
    vecs[8] = '{1'b0, 13'd8191, '0,   '0,        merge('0, d3, 6'b010010)};
    vecs[9] = '{1'b0, 13'd0,    '0,   '0,        '0};

    repeat (3) @(posedge clock);
    #1;
    reset_checks("rst");
    reset_n = 1'b1;
    init_check();

    for (int i = 0; i < 10; i++) do_op(vecs[i]);
    drain();

    // Read-to-response latency on an empty pipeline.
    bus.rd_valid = 1'b1; bus.rd_addr = 13'd5;
    @(negedge clock);
    check("lat_grant", bus.rd_ready, 1'b1);
    exp_q.push_back(exp5);
    realign();
    bus.rd_valid = 1'b0;
    @(negedge clock);
    check("lat_n1_resp_valid", bus.resp_valid, 1'b0);
    @(negedge clock);
    check("lat_n2_resp_valid", bus.resp_valid, 1'b1);
    drain();

    // Credit limit with a stalled consumer.
    for (int k = 0; k < 4; k++) begin
      wd[k] = rand_data();
      v = '{1'b1, ADDR_W'(10 + k), wd[k], 6'b111111, '0};
      do_op(v);
    end
    bus.resp_ready = 1'b0;
    grants = 0;
    bus.rd_valid = 1'b1; bus.rd_addr = 13'd10;
    for (int t = 0; t < 8; t++) begin
      @(negedge clock);
      if (bus.rd_ready) begin
        exp_q.push_back(wd[grants]);
        grants++;
      end
      realign();
      bus.rd_addr = ADDR_W'(10 + grants);
    end
    check("credit_grants", 32'(grants), 32'd3);
    @(negedge clock);
    check("credit_rd_ready", bus.rd_ready, 1'b0);
    realign();
    bus.resp_ready = 1'b1;
    realign();
    bus.resp_ready = 1'b0;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clock);
      got = bus.rd_ready;
    end
    if (!got) fail_now("credit_fourth_grant");
    else exp_q.push_back(wd[3]);
    realign();
    bus.rd_valid = 1'b0;
    bus.resp_ready = 1'b1;
    drain();

    // Back-to-back reads with an always-ready consumer.
    for (int k = 0; k < 3; k++) begin
      wd[k] = rand_data();
      v = '{1'b1, ADDR_W'(1 + k), wd[k], 6'b111111, '0};
      do_op(v);
    end
    resp_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      v = '{1'b0, ADDR_W'(1 + k), '0, '0, wd[k]};
      do_op(v);
    end
    drain();
    check("b2b_resp_count", 32'(resp_cyc.size()), 32'd3);
    if (resp_cyc.size() == 3) begin
      check("b2b_gap0", 32'(resp_cyc[1] - resp_cyc[0]), 32'd1);
      check("b2b_gap1", 32'(resp_cyc[2] - resp_cyc[1]), 32'd1);
    end

    // Both channels saturated: the read wins every fourth cycle.
    bus.wr_valid = 1'b1; bus.wr_addr = 13'd200; bus.wr_data = d1; bus.wr_mask = '1;
    bus.rd_valid = 1'b1; bus.rd_addr = 13'd300;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      w = bus.wr_valid && bus.wr_ready;
      r = bus.rd_valid && bus.rd_ready;
      check("arb_pattern", {w, r}, (i % 4 == 3) ? 2'b01 : 2'b10);
      if (r) exp_q.push_back('0);
      realign();
    end
    idle();
    drain();

    // Reset with two responses buffered.
    bus.resp_ready = 1'b0;
    v = '{1'b0, 13'd1, '0, '0, wd[0]};
    do_op(v);
    v = '{1'b0, 13'd2, '0, '0, wd[1]};
    do_op(v);
    @(negedge clock);
    @(negedge clock);
    check("pre_reset_resp_valid", bus.resp_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    reset_checks("midrst");
    exp_q.delete();
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    init_check();
    check("post_reset_resp_valid", bus.resp_valid, 1'b0);
    v = '{1'b0, 13'd7, '0, '0, '0};
    do_op(v);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_array_ctrl.md
SRAM_ARRAY_CTRL -- requirements
Module: sram_array_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 13: SRAM word-address width (8192 words).
REQ-002 SHALL have parameter LANES, default 6: number of write-mask lanes.
REQ-003 SHALL have parameter LANE_W, default 29: bits per lane; DATA_W = LANES*LANE_W = 174.
REQ-004 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports wr_valid in 1, wr_ready out 1, wr_addr in ADDR_W, wr_data in DATA_W, wr_mask in LANES: masked write request channel.
REQ-007 SHALL have ports rd_valid in 1, rd_ready out 1, rd_addr in ADDR_W: read request channel.
REQ-008 SHALL have ports resp_valid out 1, resp_ready in 1, resp_data out DATA_W: read response channel.
REQ-009 SHALL have ports sram_en out 1, sram_wmode out 1, sram_addr out ADDR_W, sram_wmask out LANES, sram_wdata out DATA_W, sram_rdata in DATA_W: single-port SRAM macro port; the macro returns read data 1 cycle after the read enable.
REQ-010 SHALL have port init_done, output, 1: high once the post-reset array clear is complete.

Function
REQ-011 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-012 In INIT, SHALL write all-zero data with full mask to addresses 0..2^ADDR_W-1, one per cycle, incrementing; after the write to the last address, SHALL go to RUN on the next cycle.
REQ-013 In INIT, wr_ready and rd_ready SHALL be 0 and init_done SHALL be 0; in RUN, init_done SHALL be 1.
REQ-014 A handshake SHALL occur when valid and ready are both high at a rising edge; the granted request drives the sram_* outputs combinationally in that same cycle.
REQ-015 In RUN, wr_ready SHALL be 1 unless a read is granted that cycle; rd_ready SHALL be 1 only if (fifo_count + inflight) < 3, and no write is granted that cycle.
REQ-016 Arbitration: a write has priority; if both are valid and rd may issue, and starve_cnt == 3, the read SHALL win and starve_cnt SHALL clear.
REQ-017 starve_cnt (2 bits) SHALL increment on each write grant while a read is pending and blocked, clear on any read grant, and saturate at 3.
REQ-018 Idle cycles SHALL drive sram_en = 0 with sram_wmode, sram_addr, sram_wmask and sram_wdata at 0.
REQ-019 inflight SHALL be 1 in the cycle after a read grant and 0 otherwise; in that cycle sram_rdata SHALL be pushed into a 3-entry response FIFO.
REQ-020 resp_valid SHALL equal FIFO non-empty, and resp_data SHALL equal the FIFO head; a pop occurs on resp_valid && resp_ready.
REQ-021 Read-to-response latency SHALL be 2 cycles minimum (grant at N, resp_valid at N+2); responses SHALL stay in request order.
REQ-022 With resp_ready held at 1, reads SHALL sustain 1 grant per cycle.
REQ-023 A simultaneous push and pop SHALL leave the count unchanged; the FIFO SHALL never overflow, because rd_ready enforces the credit limit.
REQ-024 A write followed by a read of the same address in the next cycle SHALL return the new data; port serialisation guarantees this.

Reset
REQ-025 Asserting reset_n low SHALL asynchronously clear state to INIT, init address 0, starve_cnt 0, inflight 0, and FIFO pointers and count to 0.
REQ-026 During reset: resp_valid 0, init_done 0, wr_ready 0, rd_ready 0, sram_en 0.
REQ-027 Reset during RUN SHALL discard in-flight and buffered responses; after release, INIT SHALL restart from address 0.

Structure
REQ-028 ADDR_W, LANES, LANE_W, DATA_W, the FSM state enum, and RESP_DEPTH = 3 SHALL live in the shared package sram_ctrl_pkg.
REQ-029 The response FIFO SHALL be the sub-module sram_resp_fifo (depth 3, width DATA_W, count output); the arbiter and FSM SHALL stay in the top module.

Verification
REQ-030 Release reset -> sram_en = 1 and wmode = 1 for exactly 8192 cycles with addresses 0..8191, then init_done = 1.
REQ-031 Write addr 5, data all-ones, mask 6'b000101, then read addr 5 -> resp_data has lanes 0 and 2 all-ones and other lanes 0, with resp_valid 2 cycles after the read grant.
REQ-032 resp_ready = 0 with 4 back-to-back reads -> 3 granted, rd_ready = 0; after one pop, the 4th is granted.
REQ-033 wr_valid and rd_valid held high continuously -> grant pattern W,W,W,R repeating.
REQ-034 Reset asserted mid-stream with 2 responses buffered -> resp_valid drops immediately and INIT restarts at address 0.
REQ-035 Reads of addrs 1,2,3 on consecutive cycles with resp_ready = 1 -> responses on consecutive cycles, in order.
